// File: rtl/pkt_tx_sched_pkg.sv
// Purpose: shared constants and types for the packet transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pkt_tx_sched_pkg;

    // Default packet word: [133:132] header, [131:128] byte info, [127:0] payload
    localparam int WORD_W = 134;

    // Header codes carried in the two top bits of every word
    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    // Scheduler FSM: wait for an eligible port, then stream one packet
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/pkt_tx_sched_if.sv
// Purpose: bundles the per-port read side and the transmit FIFO write side.
// Latency: n/a (wiring only).
// Backpressure: out_almostfull from the transmit FIFO throttles the scheduler.
interface pkt_tx_sched_if #(
    parameter int NUM_PORTS = 4,
    parameter int WORD_W    = 134
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        port_en;
    logic [NUM_PORTS-1:0]        pkt_rdy;
    logic [NUM_PORTS-1:0]        pkt_valid_q;
    logic [NUM_PORTS*WORD_W-1:0] data_q;
    logic [NUM_PORTS-1:0]        data_rdreq;
    logic [NUM_PORTS-1:0]        valid_rdreq;
    logic                        out_data_wrreq;
    logic [WORD_W-1:0]           out_data;
    logic                        out_valid_wrreq;
    logic                        out_valid;
    logic                        out_almostfull;
    logic                        grant_pulse;
    logic [IDX_W-1:0]            grant_port;
    logic                        fmt_err;

    // Scheduler side
    modport master (
        input  port_en, pkt_rdy, pkt_valid_q, data_q, out_almostfull,
        output data_rdreq, valid_rdreq, out_data_wrreq, out_data,
               out_valid_wrreq, out_valid, grant_pulse, grant_port, fmt_err
    );

    // Port FIFOs / transmit FIFO side
    modport slave (
        output port_en, pkt_rdy, pkt_valid_q, data_q, out_almostfull,
        input  data_rdreq, valid_rdreq, out_data_wrreq, out_data,
               out_valid_wrreq, out_valid, grant_pulse, grant_port, fmt_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick among requesters, searching from last+1 upward.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides whether the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] probe;

    // Walk the ring starting one past the previous winner; first requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        probe   = '0;
        for (int k = 1; k <= N; k++) begin
            probe = IW'((int'(last) + k) % N);
            if (!any && req[probe]) begin
                any        = 1'b1;
                gnt[probe] = 1'b1;
                gnt_idx    = probe;
            end
        end
    end

endmodule

// File: rtl/pkt_tx_sched.sv
// Purpose: round-robin packet scheduler moving whole packets from N ports to one transmit FIFO.
// Latency: grant registered 1 cycle after decision; each popped word written 1 cycle later.
// Backpressure: out_almostfull blocks new grants and word pops; state holds until it drops.
module pkt_tx_sched #(
    parameter int NUM_PORTS = 4,
    parameter int WORD_W    = pkt_tx_sched_pkg::WORD_W
) (
    input  logic           clk,
    input  logic           reset,
    pkt_tx_sched_if.master bus
);
    import pkt_tx_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_PORTS);

    state_t               state;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     cur;
    logic                 vflag;
    logic                 first_word;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic                 grant_now;
    logic                 pop_now;
    logic [WORD_W-1:0]    head_word;
    logic [1:0]           head_hdr;

    assign eligible = bus.pkt_rdy & bus.port_en;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req     (eligible),
        .last    (last_grant),
        .gnt     (win_oh),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    // Pops are gated by reset so nothing leaves the port FIFOs while held in reset
    assign grant_now = reset && (state == ST_IDLE) && win_any && !bus.out_almostfull;
    assign pop_now   = reset && (state == ST_XFER) && !bus.out_almostfull;

    assign head_word = bus.data_q[int'(cur)*WORD_W +: WORD_W];
    assign head_hdr  = head_word[WORD_W-1 -: 2];

    // Read strobes: flag pop on the grant cycle, one word pop per unstalled XFER cycle
    always_comb begin
        bus.valid_rdreq = '0;
        bus.data_rdreq  = '0;
        if (grant_now) begin
            bus.valid_rdreq = win_oh;
        end
        if (pop_now) begin
            bus.data_rdreq[cur] = 1'b1;
        end
    end

    // Scheduler FSM with registered grant, write and framing-check outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= ST_IDLE;
            last_grant          <= IDX_W'(NUM_PORTS - 1);
            cur                 <= '0;
            vflag               <= 1'b0;
            first_word          <= 1'b0;
            bus.out_data_wrreq  <= 1'b0;
            bus.out_data        <= '0;
            bus.out_valid_wrreq <= 1'b0;
            bus.out_valid       <= 1'b0;
            bus.grant_pulse     <= 1'b0;
            bus.grant_port      <= '0;
            bus.fmt_err         <= 1'b0;
        end else begin
            bus.grant_pulse     <= 1'b0;
            bus.out_data_wrreq  <= 1'b0;
            bus.out_valid_wrreq <= 1'b0;
            bus.out_valid       <= 1'b0;
            bus.fmt_err         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        state           <= ST_XFER;
                        cur             <= win_idx;
                        last_grant      <= win_idx;
                        vflag           <= bus.pkt_valid_q[win_idx];
                        first_word      <= 1'b1;
                        bus.grant_pulse <= 1'b1;
                        bus.grant_port  <= win_idx;
                    end
                end
                ST_XFER: begin
                    if (pop_now) begin
                        bus.out_data_wrreq <= 1'b1;
                        bus.out_data       <= head_word;
                        first_word         <= 1'b0;
                        // A head must open the packet and must not appear again inside it
                        bus.fmt_err <= first_word ? (head_hdr != HDR_HEAD)
                                                  : (head_hdr == HDR_HEAD);
                        if (head_hdr == HDR_TAIL) begin
                            bus.out_valid_wrreq <= 1'b1;
                            bus.out_valid       <= vflag;
                            state               <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Purpose: scoreboard bench for pkt_tx_sched with modelled show-ahead port FIFOs.
// Latency: checks grant and write timing through the scoreboard order.
// Backpressure: exercises out_almostfull stalls mid-packet.
module tb_pkt_tx_sched;
    import pkt_tx_sched_pkg::*;

    localparam int NP = 4;
    localparam int W  = 134;

    logic clk = 1'b0;
    logic reset;

    pkt_tx_sched_if #(.NUM_PORTS(NP), .WORD_W(W)) bus ();

    pkt_tx_sched #(.NUM_PORTS(NP), .WORD_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dat;
        bit           tail;
        bit           vf;
        bit           fe;
    } exp_t;

    exp_t         exp_q[$];
    int           exp_gnt[$];
    logic [W-1:0] src_w[NP][$];
    bit           src_f[NP][$];
    int           checks = 0;
    int           errors = 0;
    logic [NP-1:0] dr;
    logic [NP-1:0] vr;
    exp_t         mon_e;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive the show-ahead view of every port FIFO from the model queues
    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            bus.pkt_rdy[i]     = (src_f[i].size() != 0);
            bus.pkt_valid_q[i] = (src_f[i].size() != 0) ? src_f[i][0] : 1'b0;
            bus.data_q[i*W +: W] = (src_w[i].size() != 0) ? src_w[i][0] : '0;
        end
    endtask

    function automatic logic [W-1:0] mkword(input logic [1:0] h, input int tag);
        return {h, 4'hF, 128'(tag)};
    endfunction

    // Load a packet into port p; the first n_exp words become expected writes
    task automatic add_pkt(input int p, input int n, input bit vf, input bit bad_mid,
                           input int n_exp, input int tag);
        logic [1:0]   h;
        logic [W-1:0] w;
        exp_t         e;
        for (int k = 0; k < n; k++) begin
            h = (k == 0) ? HDR_HEAD : ((k == n - 1) ? HDR_TAIL : HDR_MID);
            if (bad_mid && k == 2 && n > 3) h = HDR_HEAD;
            w = mkword(h, tag + k);
            src_w[p].push_back(w);
            if (k < n_exp) begin
                e.dat  = w;
                e.tail = (k == n - 1);
                e.vf   = vf;
                e.fe   = (k == 0) ? (h != HDR_HEAD) : (h == HDR_HEAD);
                exp_q.push_back(e);
            end
        end
        src_f[p].push_back(vf);
        refresh();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wrreq"},  W'(bus.out_data_wrreq),  '0);
        chk({tag, "_data"},   bus.out_data,            '0);
        chk({tag, "_vwrreq"}, W'(bus.out_valid_wrreq), '0);
        chk({tag, "_valid"},  W'(bus.out_valid),       '0);
        chk({tag, "_gpulse"}, W'(bus.grant_pulse),     '0);
        chk({tag, "_gport"},  W'(bus.grant_port),      '0);
        chk({tag, "_fmterr"}, W'(bus.fmt_err),         '0);
        chk({tag, "_drd"},    W'(bus.data_rdreq),      '0);
        chk({tag, "_vrd"},    W'(bus.valid_rdreq),     '0);
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!bus.grant_pulse && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.grant_pulse) begin
            checks++;
            errors++;
            $display("FAIL %s_grant_timeout actual=no_grant required=grant_pulse", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp_gnt.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_words_left"},  W'(exp_q.size()),   '0);
        chk({name, "_grants_left"}, W'(exp_gnt.size()), '0);
    endtask

    // Port FIFO model: pop on the edge where the DUT strobes a read
    initial begin
        forever begin
            @(posedge clk);
            dr = bus.data_rdreq;
            vr = bus.valid_rdreq;
            #1;
            for (int i = 0; i < NP; i++) begin
                if (dr[i]) begin
                    if (src_w[i].size() != 0) void'(src_w[i].pop_front());
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL data_underflow port=%0d actual=pop required=no_pop", i);
                    end
                end
                if (vr[i]) begin
                    if (src_f[i].size() != 0) void'(src_f[i].pop_front());
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL flag_underflow port=%0d actual=pop required=no_pop", i);
                    end
                end
            end
            refresh();
        end
    end

    // Monitor: compare every grant and every write against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (bus.grant_pulse) begin
                if (exp_gnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=%0d required=none", bus.grant_port);
                end else begin
                    chk("grant_port", W'(bus.grant_port), W'(exp_gnt.pop_front()));
                end
            end
            if (bus.out_data_wrreq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", bus.out_data, mon_e.dat);
                    chk("fmt_err", W'(bus.fmt_err), W'(mon_e.fe));
                    chk("out_valid_wrreq", W'(bus.out_valid_wrreq), W'(mon_e.tail));
                    if (mon_e.tail) chk("out_valid", W'(bus.out_valid), W'(mon_e.vf));
                end
            end else if (bus.out_valid_wrreq || bus.fmt_err) begin
                checks++;
                errors++;
                $display("FAIL stray_strobe actual=vwr%0d_fe%0d required=0", bus.out_valid_wrreq, bus.fmt_err);
            end
        end
    end

    initial begin
        reset              = 1'b0;
        bus.port_en        = '1;
        bus.out_almostfull = 1'b0;
        bus.pkt_rdy        = '0;
        bus.pkt_valid_q    = '0;
        bus.data_q         = '0;
        refresh();
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b1;

        // Single 4-word valid packet from port 1
        add_pkt(1, 4, 1'b1, 1'b0, 4, 'h100);
        exp_gnt.push_back(1);
        drain("t1");

        // Back to reset state, then all ports ready: order 0,1,2,3 and wrap to 0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        add_pkt(0, 2, 1'b1, 1'b0, 2, 'h200);
        add_pkt(1, 2, 1'b1, 1'b0, 2, 'h210);
        add_pkt(2, 2, 1'b1, 1'b0, 2, 'h220);
        add_pkt(3, 2, 1'b1, 1'b0, 2, 'h230);
        add_pkt(0, 2, 1'b1, 1'b0, 2, 'h240);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        exp_gnt.push_back(3);
        exp_gnt.push_back(0);
        drain("t2");

        // 5-word packet with a 3-cycle almost-full stall after the second word
        add_pkt(3, 5, 1'b1, 1'b0, 5, 'h300);
        exp_gnt.push_back(3);
        wait_grant("t3");
        @(negedge clk);
        @(negedge clk);
        bus.out_almostfull = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wrreq", W'(bus.out_data_wrreq), '0);
            chk("stall_rdreq", W'(bus.data_rdreq), '0);
        end
        bus.out_almostfull = 1'b0;
        drain("t3");

        // Invalid-flag packet forwarded with out_valid low on the tail
        add_pkt(2, 3, 1'b0, 1'b0, 3, 'h400);
        exp_gnt.push_back(2);
        drain("t4");

        // Stray head as third word: single framing error, packet still completes
        add_pkt(0, 4, 1'b1, 1'b1, 4, 'h500);
        exp_gnt.push_back(0);
        drain("t5");

        // Reset while the second word of a 6-word packet would be popped
        add_pkt(1, 6, 1'b1, 1'b0, 1, 'h600);
        exp_gnt.push_back(1);
        wait_grant("t6");
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        src_w[1].delete();
        src_f[1].delete();
        add_pkt(0, 2, 1'b1, 1'b0, 2, 'h610);
        add_pkt(2, 2, 1'b1, 1'b0, 2, 'h620);
        exp_gnt.push_back(0);
        exp_gnt.push_back(2);
        @(negedge clk);
        reset = 1'b1;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_tx_sched.md
PKT_TX_SCHED -- requirements
Module: pkt_tx_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of packet requesters.
REQ-002 SHALL have parameter WORD_W, default 134, packet word width ([133:132] header, [131:128] byte info, [127:0] payload).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 port_en  in  NUM_PORTS  per-port scheduling enable.
REQ-006 pkt_rdy  in  NUM_PORTS  port i valid-flag FIFO non-empty (complete packet stored).
REQ-007 pkt_valid_q  in  NUM_PORTS  show-ahead valid flag of port i head packet.
REQ-008 data_q  in  NUM_PORTS*WORD_W  show-ahead data word of port i, port i at [i*WORD_W +: WORD_W].
REQ-009 data_rdreq  out  NUM_PORTS  pop one data word from port i.
REQ-010 valid_rdreq  out  NUM_PORTS  pop one valid flag from port i.
REQ-011 out_data_wrreq  out  1  write strobe to transmit data FIFO.
REQ-012 out_data  out  WORD_W  word to transmit data FIFO.
REQ-013 out_valid_wrreq  out  1  write strobe to transmit valid FIFO.
REQ-014 out_valid  out  1  packet valid flag (1 keep, 0 discard downstream).
REQ-015 out_almostfull  in  1  transmit data FIFO almost full; no new word may be popped while high.
REQ-016 grant_pulse  out  1  one-cycle pulse per packet granted.
REQ-017 grant_port  out  2  port index of current/last grant.
REQ-018 fmt_err  out  1  one-cycle pulse on header framing error.

Function
REQ-019 Header codes SHALL be: 01 head, 11 middle, 10 tail; head+tail in one word not supported.
REQ-020 FSM states SHALL be IDLE and XFER only.
REQ-021 IDLE: eligible = pkt_rdy & port_en; if eligible!=0 and out_almostfull=0, SHALL pick winner round-robin starting at last_grant+1, pulse valid_rdreq[winner] that cycle, latch pkt_valid_q[winner], go XFER.
REQ-022 grant_pulse and grant_port SHALL be registered, asserting the cycle after the IDLE grant decision.
REQ-023 XFER: data_rdreq[grant] SHALL be combinational = (out_almostfull==0); all other data_rdreq and valid_rdreq 0.
REQ-024 out_data/out_data_wrreq SHALL be registered: word popped in cycle N appears with out_data_wrreq=1 in cycle N+1 (latency 1).
REQ-025 When the popped word has header 10, out_valid_wrreq=1 and out_valid=latched flag SHALL appear in the same cycle as that tail word on out_data, and FSM SHALL return to IDLE.
REQ-026 Minimum gap: IDLE grant cycle between packets; at most one packet in flight.
REQ-027 out_almostfull high in XFER SHALL stall with no pop and out_data_wrreq=0; resume next low cycle, no word lost or duplicated.
REQ-028 Invalid packets (flag 0) SHALL be forwarded unchanged; discarding is downstream.
REQ-029 Popped word with header 01 not first in packet, or first word header not 01, SHALL pulse fmt_err in the write cycle; transfer continues until tail.
REQ-030 port_en deassert mid-packet SHALL NOT abort; affects next arbitration only.
REQ-031 last_grant SHALL update only on grant; ports not eligible are skipped; single eligible port may win consecutively.
REQ-032 pkt_rdy high but pkt_valid_q unchanged SHALL not matter; only the grant cycle sample is used.

Reset
REQ-033 On reset low at clk edge: FSM IDLE, last_grant=NUM_PORTS-1 (port 0 first), all outputs 0, out_data 0, latched flag 0.
REQ-034 Reset mid-packet SHALL abandon transfer; recovery of partial packets upstream/downstream is system responsibility.

Structure
REQ-035 Shared package SHALL hold WORD_W, header code constants HDR_HEAD/HDR_MID/HDR_TAIL, and FSM state encoding.
REQ-036 Round-robin selection SHALL be sub-module rr_arbiter (request vector, last pointer, one-hot grant, index).

Verification
REQ-037 Port 1 only, 4-word valid packet (01,11,11,10): 4 out_data_wrreq cycles, out_valid_wrreq=1/out_valid=1 with 4th word, grant_port=1.
REQ-038 All 4 ports ready, 1-word-head+tail 2-word packets each: grant order 0,1,2,3, then 0 again after reset state.
REQ-039 out_almostfull high 3 cycles mid 5-word packet: exactly 5 writes, no duplicates, data order preserved.
REQ-040 Port 2 packet with flag 0: forwarded with out_valid=0 on tail cycle.
REQ-041 Words 01,11,01,10: fmt_err single pulse on 3rd word write, packet completes.
REQ-042 Reset asserted on 2nd word of 6-word packet: next cycle all outputs 0, FSM IDLE, next grant goes to port 0.
